// File: rtl/pattern_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_serializer
// Brief    : Decodes a 3-bit select into an 8-bit code word and shifts it out
//            MSB-first on a serial line, optionally followed by even parity.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_serializer #(
    parameter int unsigned PARITY = 0,
    parameter logic [7:0]  PAT_A  = 8'b10001101,
    parameter logic [7:0]  PAT_B  = 8'b00110010,
    parameter logic [7:0]  PAT_D  = 8'b11000101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_valid,
    input  logic [2:0] sel,
    output logic       sel_ready,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       frame_start,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam logic [2:0] c_LAST_BIT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] frame_cnt_q;
    logic       sel_ready_q;
    logic       ser_out_q;
    logic       ser_valid_q;
    logic       frame_start_q;
    logic       busy_q;

    logic [7:0] w_code;
    logic       w_accept;

    // Wildcard rule A (1?0) outranks the exact match of rule B.
    always_comb begin
        if (sel[2] && !sel[0]) begin
            w_code = PAT_A;
        end else if (sel == 3'b101) begin
            w_code = PAT_B;
        end else begin
            w_code = PAT_D;
        end
    end

    assign w_accept = sel_valid && sel_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_GAP;
            shift_q       <= 8'd0;
            data_q        <= 8'd0;
            bit_cnt_q     <= 3'd0;
            frame_cnt_q   <= 8'd0;
            sel_ready_q   <= 1'b0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ser_valid_q <= 1'b0;
                    ser_out_q   <= 1'b0;
                    if (w_accept) begin
                        shift_q     <= w_code;
                        data_q      <= w_code;
                        bit_cnt_q   <= 3'd0;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        sel_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    ser_valid_q   <= 1'b1;
                    ser_out_q     <= shift_q[7];
                    frame_start_q <= (bit_cnt_q == 3'd0);
                    shift_q       <= {shift_q[6:0], 1'b0};
                    bit_cnt_q     <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == c_LAST_BIT) begin
                        if (PARITY != 0) begin
                            state_q <= ST_PAR;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_PAR: begin
                    // Parity comes from the word latched at accept, not live sel.
                    ser_valid_q <= 1'b1;
                    ser_out_q   <= ^data_q;
                    busy_q      <= 1'b0;
                    state_q     <= ST_GAP;
                end
                default: begin
                    ser_valid_q <= 1'b0;
                    ser_out_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    sel_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel_ready   = sel_ready_q;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pattern_serializer
// Brief    : Scoreboard bench for pattern_serializer, with and without parity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_serializer;

    typedef struct packed {
        logic b;
        logic fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_valid = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       sel_ready, ser_out, ser_valid, frame_start, busy;
    logic [7:0] frame_cnt;

    logic       sel_valid_p = 1'b0;
    logic [2:0] sel_p = 3'd0;
    logic       sel_ready_p, ser_out_p, ser_valid_p, frame_start_p, busy_p;
    logic [7:0] frame_cnt_p;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_cnt0 = 8'd0;
    logic [7:0] exp_cnt1 = 8'd0;
    time        last_acc0 = 0;
    time        last_acc1 = 0;

    always #5 clk = ~clk;

    pattern_serializer #(.PARITY(0)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel(sel),
        .sel_ready(sel_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt)
    );

    pattern_serializer #(.PARITY(1)) dut_p (
        .clk(clk), .rst(rst), .sel_valid(sel_valid_p), .sel(sel_p),
        .sel_ready(sel_ready_p), .ser_out(ser_out_p), .ser_valid(ser_valid_p),
        .frame_start(frame_start_p), .busy(busy_p), .frame_cnt(frame_cnt_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expected bit whenever a DUT presents a valid serial bit.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst) begin
            if (ser_valid) begin
                if (q0.size() == 0) begin
                    check("unexpected_bit0", {31'd0, ser_valid}, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("ser_out0", {31'd0, ser_out}, {31'd0, e.b});
                    check("frame_start0", {31'd0, frame_start}, {31'd0, e.fs});
                end
            end else begin
                check("frame_start_idle0", {31'd0, frame_start}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst) begin
            if (ser_valid_p) begin
                if (q1.size() == 0) begin
                    check("unexpected_bit1", {31'd0, ser_valid_p}, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("ser_out1", {31'd0, ser_out_p}, {31'd0, e.b});
                    check("frame_start1", {31'd0, frame_start_p}, {31'd0, e.fs});
                end
            end else begin
                check("frame_start_idle1", {31'd0, frame_start_p}, 32'd0);
            end
        end
    end

    // Called at a negedge; offers s and waits (bounded) for the accept edge.
    task automatic send0(input logic [2:0] s, input logic [7:0] code,
                         input bit hold, input int exp_period);
        int t = 0;
        sel = s;
        sel_valid = 1'b1;
        while (!sel_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait0", {31'd0, sel_ready}, 32'd1);
        if (!sel_ready) begin
            sel_valid = 1'b0;
            return;
        end
        for (int i = 7; i >= 0; i--) q0.push_back(exp_t'{b: code[i], fs: (i == 7)});
        @(posedge clk);
        if (exp_period != 0) check("period0", int'(($time - last_acc0) / 10), exp_period);
        last_acc0 = $time;
        exp_cnt0 = exp_cnt0 + 8'd1;
        @(negedge clk);
        check("frame_cnt0", {24'd0, frame_cnt}, {24'd0, exp_cnt0});
        check("ready_drop0", {31'd0, sel_ready}, 32'd0);
        check("busy0", {31'd0, busy}, 32'd1);
        if (!hold) sel_valid = 1'b0;
    endtask

    task automatic send1(input logic [2:0] s, input logic [7:0] code, input logic par,
                         input bit hold, input int exp_period);
        int t = 0;
        sel_p = s;
        sel_valid_p = 1'b1;
        while (!sel_ready_p && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait1", {31'd0, sel_ready_p}, 32'd1);
        if (!sel_ready_p) begin
            sel_valid_p = 1'b0;
            return;
        end
        for (int i = 7; i >= 0; i--) q1.push_back(exp_t'{b: code[i], fs: (i == 7)});
        q1.push_back(exp_t'{b: par, fs: 1'b0});
        @(posedge clk);
        if (exp_period != 0) check("period1", int'(($time - last_acc1) / 10), exp_period);
        last_acc1 = $time;
        exp_cnt1 = exp_cnt1 + 8'd1;
        @(negedge clk);
        check("frame_cnt1", {24'd0, frame_cnt_p}, {24'd0, exp_cnt1});
        if (!hold) sel_valid_p = 1'b0;
    endtask

    initial begin
        logic [2:0] s;
        logic [7:0] c;
        int t;

        repeat (2) @(negedge clk);
        check("rst_sel_ready", {31'd0, sel_ready}, 32'd0);
        check("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
        check("rst_ser_out", {31'd0, ser_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst_sel_ready_p", {31'd0, sel_ready_p}, 32'd0);

        #2 rst = 1'b0;
        sel = 3'b100;
        sel_valid = 1'b1;
        #1 check("ready_before_edge", {31'd0, sel_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_release", {31'd0, sel_ready}, 32'd1);

        send0(3'b100, 8'h8D, 1'b0, 0);
        send0(3'b110, 8'h8D, 1'b0, 0);
        send0(3'b101, 8'h32, 1'b0, 0);
        send0(3'b000, 8'hC5, 1'b0, 0);
        send0(3'b111, 8'hC5, 1'b0, 0);
        send0(3'b001, 8'hC5, 1'b0, 0);
        send0(3'b010, 8'hC5, 1'b0, 0);
        send0(3'b011, 8'hC5, 1'b0, 0);

        send1(3'b101, 8'h32, 1'b1, 1'b1, 0);
        send1(3'b100, 8'h8D, 1'b0, 1'b1, 11);
        send1(3'b011, 8'hC5, 1'b0, 1'b0, 11);

        // Held request; sel changes while the previous frame is still shifting.
        send0(3'b110, 8'h8D, 1'b1, 0);
        repeat (3) @(negedge clk);
        send0(3'b101, 8'h32, 1'b1, 10);
        repeat (3) @(negedge clk);
        send0(3'b000, 8'hC5, 1'b0, 10);

        send0(3'b100, 8'h8D, 1'b0, 0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        q0.delete();
        #1;
        check("abort_ser_valid", {31'd0, ser_valid}, 32'd0);
        check("abort_ser_out", {31'd0, ser_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sel_ready", {31'd0, sel_ready}, 32'd0);
        check("abort_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        exp_cnt0 = 8'd0;
        exp_cnt1 = 8'd0;
        @(negedge clk);
        send0(3'b101, 8'h32, 1'b0, 0);

        for (int i = 0; i < 256; i++) begin
            case (i % 4)
                0:       begin s = 3'b100; c = 8'h8D; end
                1:       begin s = 3'b101; c = 8'h32; end
                2:       begin s = 3'b001; c = 8'hC5; end
                default: begin s = 3'b110; c = 8'h8D; end
            endcase
            send0(s, c, (i < 255), (i == 0) ? 0 : 10);
        end

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("drain0", q0.size(), 32'd0);
        check("drain1", q1.size(), 32'd0);
        check("final_frame_cnt", {24'd0, frame_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
